dram_mig_nport_adapter: RTL and testbench

- Parametrised successor to the single-client MIG glue for the DDR2 SODIMM path.
- Arbitrates NPORT client request ports onto one MIG app interface (address FIFO + write-data FIFO + read-data return) in the MIG user clock domain.
- Serialises multi-beat write bursts, bounds outstanding reads, and routes returned read beats to the issuing port through an in-order tag FIFO.

---
 rtl/dram_mig_nport_adapter.sv | 172 +++++++++++++++++
 tb/tb_dram_mig_nport_adapter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_mig_nport_adapter.sv
// NPORT-client arbiter onto a single MIG app interface: serialises write bursts,
// caps outstanding reads and routes read beats back through an in-order tag FIFO.
module dram_mig_nport_adapter #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned ADDRPAD   = 2,
  parameter int unsigned DW        = 128,
  parameter int unsigned BURST     = 2,
  parameter int unsigned RDQ_DEPTH = 8
) (
  input  logic                          clk0,
  input  logic                          rst0,
  input  logic [NPORT-1:0]              req_valid,
  output logic [NPORT-1:0]              req_ready,
  input  logic [NPORT-1:0]              req_we,
  input  logic [NPORT*ADDR_W-1:0]       req_addr,
  input  logic [NPORT*BURST*DW-1:0]     req_wdata,
  output logic [NPORT-1:0]              rsp_valid,
  output logic [DW-1:0]                 rsp_data,
  output logic                          rsp_last,
  output logic                          app_af_wren,
  output logic [30:0]                   app_af_addr,
  output logic [2:0]                    app_af_cmd,
  input  logic                          app_af_afull,
  output logic                          app_wdf_wren,
  output logic [DW-1:0]                 app_wdf_data,
  output logic [DW/8-1:0]               app_wdf_mask_data,
  input  logic                          app_wdf_afull,
  input  logic                          rd_data_valid,
  input  logic [DW-1:0]                 rd_data_fifo_out,
  output logic [$clog2(RDQ_DEPTH):0]    rd_outstanding,
  output logic                          protocol_err
);

  localparam int unsigned PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned QW = $clog2(RDQ_DEPTH);
  localparam int unsigned CW = QW + 1;
  localparam int unsigned LW = BURST * DW;

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_CMD} state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_rr_ptr, r_win, w_win;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [LW-1:0]       r_wdata;
  logic [BW-1:0]       r_wbeat, r_rbeat;
  logic [PW-1:0]       r_tags [RDQ_DEPTH];
  logic [QW-1:0]       r_wptr, r_rptr;
  logic [CW-1:0]       r_count;
  logic [NPORT-1:0]    r_rsp_valid;
  logic [DW-1:0]       r_rsp_data;
  logic                r_rsp_last, r_perr;
  logic [NPORT-1:0]    w_elig;
  logic                w_found, w_tag_full, w_af_wren, w_wdf_wren;
  logic                w_push, w_rd_ok, w_pop;

  assign w_tag_full = (r_count == CW'(RDQ_DEPTH));
  assign w_elig     = req_valid & (req_we | {NPORT{~w_tag_full}});

  // Round-robin search starting at the pointer (port after the last grant)
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      if (!w_found && w_elig[PW'((int'(r_rr_ptr) + i) % NPORT)]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(r_rr_ptr) + i) % NPORT);
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_af_wren   = 1'b0;
    w_wdf_wren  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = req_we[w_win] ? S_WDATA : S_CMD;
      S_WDATA: if (!app_wdf_afull) begin
        w_wdf_wren = 1'b1;
        if (r_wbeat == BW'(BURST - 1)) w_state_nxt = S_CMD;
      end
      S_CMD:   if (!app_af_afull) begin
        w_af_wren   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant capture and write-beat sequencing
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wbeat  <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_win    <= w_win;
        r_we     <= req_we[w_win];
        r_addr   <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
        r_wdata  <= req_wdata[int'(w_win)*LW +: LW];
        r_rr_ptr <= (int'(w_win) == int'(NPORT) - 1) ? '0 : PW'(int'(w_win) + 1);
      end
      if (w_wdf_wren)
        r_wbeat <= (r_wbeat == BW'(BURST - 1)) ? '0 : r_wbeat + 1'b1;
    end
  end

  assign w_push  = w_af_wren && !r_we;
  assign w_rd_ok = rd_data_valid && (r_count != '0);
  assign w_pop   = w_rd_ok && (r_rbeat == BW'(BURST - 1));

  always_ff @(posedge clk0) begin
    if (w_push) r_tags[r_wptr] <= r_win;
  end

  // Tag FIFO pointers and read-return path
  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rbeat     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_perr      <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rsp_valid <= '0;
      r_rsp_last  <= 1'b0;
      if (rd_data_valid) r_rsp_data <= rd_data_fifo_out;
      if (w_rd_ok) begin
        r_rsp_valid <= NPORT'(1) << r_tags[r_rptr];
        r_rsp_last  <= w_pop;
        r_rbeat     <= w_pop ? '0 : r_rbeat + 1'b1;
      end else if (rd_data_valid) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign req_ready         = w_af_wren ? (NPORT'(1) << r_win) : '0;
  assign app_af_wren       = w_af_wren;
  assign app_af_addr       = w_af_wren ? (31'(r_addr) << ADDRPAD) : '0;
  assign app_af_cmd        = (w_af_wren && !r_we) ? 3'b001 : 3'b000;
  assign app_wdf_wren      = w_wdf_wren;
  assign app_wdf_data      = w_wdf_wren ? r_wdata[int'(r_wbeat)*DW +: DW] : '0;
  assign app_wdf_mask_data = '0;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data          = r_rsp_data;
  assign rsp_last          = r_rsp_last;
  assign rd_outstanding    = r_count;
  assign protocol_err      = r_perr;

endmodule

// File: tb/tb_dram_mig_nport_adapter.sv
// Directed bench for dram_mig_nport_adapter (NPORT=2, BURST=2, DW=128, RDQ_DEPTH=8).
module tb_dram_mig_nport_adapter;

  localparam int unsigned NPORT = 2;
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DW = 128;
  localparam int unsigned BURST = 2;
  localparam int unsigned RDQ = 8;

  logic                      clk0 = 1'b0;
  logic                      rst0;
  logic [NPORT-1:0]          req_valid, req_ready, req_we;
  logic [ADDR_W-1:0]         a0, a1;
  logic [DW-1:0]             w0b0, w0b1, w1b0, w1b1;
  logic [NPORT*ADDR_W-1:0]   req_addr;
  logic [NPORT*BURST*DW-1:0] req_wdata;
  logic [NPORT-1:0]          rsp_valid;
  logic [DW-1:0]             rsp_data;
  logic                      rsp_last;
  logic                      app_af_wren, app_af_afull;
  logic [30:0]               app_af_addr;
  logic [2:0]                app_af_cmd;
  logic                      app_wdf_wren, app_wdf_afull;
  logic [DW-1:0]             app_wdf_data;
  logic [DW/8-1:0]           app_wdf_mask_data;
  logic                      rd_data_valid;
  logic [DW-1:0]             rd_data_fifo_out;
  logic [$clog2(RDQ):0]      rd_outstanding;
  logic                      protocol_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] rr_exp [8];

  assign req_addr  = {a1, a0};
  assign req_wdata = {w1b1, w1b0, w0b1, w0b0};

  always #5 clk0 = ~clk0;

  dram_mig_nport_adapter #(
    .NPORT(NPORT), .ADDR_W(ADDR_W), .ADDRPAD(2), .DW(DW), .BURST(BURST), .RDQ_DEPTH(RDQ)
  ) dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .app_af_wren(app_af_wren), .app_af_addr(app_af_addr), .app_af_cmd(app_af_cmd),
    .app_af_afull(app_af_afull),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data), .app_wdf_afull(app_wdf_afull),
    .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out),
    .rd_outstanding(rd_outstanding), .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge, outputs checked 1 unit later.
  task automatic step();
    @(posedge clk0);
    #1;
  endtask

  task automatic do_reset();
    rst0 = 1'b1;
    req_valid = '0; req_we = '0;
    app_af_afull = 1'b0; app_wdf_afull = 1'b0;
    rd_data_valid = 1'b0; rd_data_fifo_out = '0;
    step(); step();
    rst0 = 1'b0;
  endtask

  initial begin
    a0 = '0; a1 = '0;
    w0b0 = '0; w0b1 = '0; w1b0 = '0; w1b1 = '0;
    do_reset();
    #1;
    check("rst_af_wren", app_af_wren, 0);
    check("rst_wdf_wren", app_wdf_wren, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outstanding", rd_outstanding, 0);
    check("rst_perr", protocol_err, 0);

    // Single read from port 1
    step(); req_valid = 2'b10; req_we = 2'b00; a1 = 25'h000123; #1;
    check("rd_idle_af", app_af_wren, 0);
    step(); #1;
    check("rd_af_wren", app_af_wren, 1);
    check("rd_af_addr", app_af_addr, 31'h0000048C);
    check("rd_af_cmd", app_af_cmd, 3'b001);
    check("rd_ready", req_ready, 2'b10);
    req_valid = '0;
    step(); rd_data_valid = 1'b1; rd_data_fifo_out = 128'hAAAA; #1;
    check("rd_outst1", rd_outstanding, 1);
    step(); rd_data_fifo_out = 128'hBBBB; #1;
    check("rd_b0_valid", rsp_valid, 2'b10);
    check("rd_b0_data", rsp_data, 128'hAAAA);
    check("rd_b0_last", rsp_last, 0);
    step(); rd_data_valid = 1'b0; #1;
    check("rd_b1_valid", rsp_valid, 2'b10);
    check("rd_b1_data", rsp_data, 128'hBBBB);
    check("rd_b1_last", rsp_last, 1);
    step(); #1;
    check("rd_done_valid", rsp_valid, 0);
    check("rd_done_outst", rd_outstanding, 0);

    // Single write from port 0
    w0b0 = {16{8'h11}}; w0b1 = {16{8'h22}};
    step(); req_valid = 2'b01; req_we = 2'b01; a0 = 25'h55; #1;
    step(); #1;
    check("wr_b0_wren", app_wdf_wren, 1);
    check("wr_b0_data", app_wdf_data, {16{8'h11}});
    check("wr_b0_mask", app_wdf_mask_data, 0);
    check("wr_b0_af", app_af_wren, 0);
    step(); #1;
    check("wr_b1_wren", app_wdf_wren, 1);
    check("wr_b1_data", app_wdf_data, {16{8'h22}});
    check("wr_b1_mask", app_wdf_mask_data, 0);
    step(); #1;
    check("wr_af_wren", app_af_wren, 1);
    check("wr_af_cmd", app_af_cmd, 3'b000);
    check("wr_af_addr", app_af_addr, 31'h154);
    check("wr_ready", req_ready, 2'b01);
    check("wr_cmd_wdf", app_wdf_wren, 0);
    req_valid = '0;
    step(); #1;
    check("wr_after_ready", req_ready, 0);

    // Round-robin between two continuously requesting read ports
    do_reset();
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    a0 = 25'h10; a1 = 25'h20;
    step(); req_valid = 2'b11; req_we = 2'b00; #1;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      check($sformatf("rr_ready%0d", k), req_ready, rr_exp[k]);
      check($sformatf("rr_addr%0d", k), app_af_addr, (k % 2 == 0) ? 31'h40 : 31'h80);
      if (k == 3) req_valid = '0;
      step(); #1;
      check($sformatf("rr_idle%0d", k), app_af_wren, 0);
    end
    check("rr_outst", rd_outstanding, 4);
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b10;
    rr_exp[4] = 2'b01; rr_exp[5] = 2'b01; rr_exp[6] = 2'b10; rr_exp[7] = 2'b10;
    step(); rd_data_valid = 1'b1; rd_data_fifo_out = 128'd0;
    for (int b = 0; b < 8; b++) begin
      step();
      if (b < 7) rd_data_fifo_out = 128'(b + 1);
      else rd_data_valid = 1'b0;
      #1;
      check($sformatf("rr_rsp_valid%0d", b), rsp_valid, rr_exp[b]);
      check($sformatf("rr_rsp_last%0d", b), rsp_last, (b % 2 == 1) ? 1 : 0);
      check($sformatf("rr_rsp_data%0d", b), rsp_data, 128'(b));
    end
    step(); #1;
    check("rr_outst_end", rd_outstanding, 0);
    check("rr_perr", protocol_err, 0);

    // Backpressure on both FIFOs
    do_reset();
    w0b0 = 128'hC0; w0b1 = 128'hC1; a0 = 25'h3;
    step(); req_valid = 2'b01; req_we = 2'b01; #1;
    step(); #1;
    check("bp_b0_wren", app_wdf_wren, 1);
    check("bp_b0_data", app_wdf_data, 128'hC0);
    step(); app_wdf_afull = 1'b1; #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("bp_wdf_hold%0d", s), app_wdf_wren, 0);
      if (s < 2) begin step(); #1; end
    end
    step(); app_wdf_afull = 1'b0; #1;
    check("bp_b1_wren", app_wdf_wren, 1);
    check("bp_b1_data", app_wdf_data, 128'hC1);
    step(); app_af_afull = 1'b1; #1;
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp_af_hold%0d", s), app_af_wren, 0);
      check($sformatf("bp_ready_hold%0d", s), req_ready, 0);
      if (s < 4) begin step(); #1; end
    end
    step(); app_af_afull = 1'b0; #1;
    check("bp_af_wren", app_af_wren, 1);
    check("bp_af_cmd", app_af_cmd, 3'b000);
    check("bp_ready", req_ready, 2'b01);
    req_valid = '0;

    // Outstanding-read limit; a write is still granted while reads stall
    do_reset();
    a0 = 25'h7; a1 = 25'h9; w1b0 = 128'hD0; w1b1 = 128'hD1;
    step(); req_valid = 2'b01; req_we = 2'b00; #1;
    for (int k = 0; k < 8; k++) begin
      step(); #1;
      check($sformatf("lim_ready%0d", k), req_ready, 2'b01);
      step(); #1;
    end
    check("lim_outst8", rd_outstanding, 8);
    req_valid = 2'b11; req_we = 2'b10;
    step(); #1;
    check("lim_wr_b0", app_wdf_wren, 1);
    check("lim_wr_d0", app_wdf_data, 128'hD0);
    step(); #1;
    check("lim_wr_d1", app_wdf_data, 128'hD1);
    step(); #1;
    check("lim_wr_ready", req_ready, 2'b10);
    check("lim_wr_cmd", app_af_cmd, 3'b000);
    req_valid = 2'b01; req_we = 2'b00;
    for (int s = 0; s < 3; s++) begin
      step(); #1;
      check($sformatf("lim_stall%0d", s), app_af_wren, 0);
    end
    rd_data_valid = 1'b1; rd_data_fifo_out = 128'hE0;
    step(); #1;
    check("lim_ret_valid", rsp_valid, 2'b01);
    step(); rd_data_valid = 1'b0; #1;
    check("lim_ret_last", rsp_last, 1);
    check("lim_outst7", rd_outstanding, 7);
    step(); #1;
    check("lim_9th_wren", app_af_wren, 1);
    check("lim_9th_cmd", app_af_cmd, 3'b001);
    check("lim_9th_ready", req_ready, 2'b01);
    req_valid = '0;
    step(); #1;
    check("lim_outst8b", rd_outstanding, 8);

    // Protocol error and reset mid-burst
    do_reset();
    step(); rd_data_valid = 1'b1; rd_data_fifo_out = 128'hF0; #1;
    step(); rd_data_valid = 1'b0; #1;
    check("err_perr", protocol_err, 1);
    check("err_rsp_valid", rsp_valid, 0);
    step(); #1;
    check("err_sticky", protocol_err, 1);
    w0b0 = 128'h51; w0b1 = 128'h52;
    step(); req_valid = 2'b01; req_we = 2'b01; #1;
    step(); #1;
    check("rst_mid_b0", app_wdf_wren, 1);
    rst0 = 1'b1; req_valid = '0; req_we = '0;
    step(); #1;
    check("rst_mid_wdf", app_wdf_wren, 0);
    check("rst_mid_af", app_af_wren, 0);
    check("rst_mid_perr", protocol_err, 0);
    check("rst_mid_ready", req_ready, 0);
    check("rst_mid_rsp", rsp_valid, 0);
    rst0 = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step(); #1;
      check($sformatf("rst_mid_noaf%0d", s), app_af_wren, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
